frame_sync_capture: RTL and testbench

Downstream stage of the 16-bit serial-in shift register. Each clock it examines the register's 16-bit parallel window, hunts for a sync word, and delivers the following payload as aligned 16-bit words. It then checks for the sync word once per frame and keeps a lock/loss-of-lock flywheel. Its word outputs feed the parallel data path.

---
 rtl/frame_sync_capture.sv | 148 ++++++++++++++
 tb/tb_frame_sync_capture.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_capture.sv
// frame_sync_capture
//
// Watches the 16-bit parallel window of an upstream serial-in shift register,
// hunts for a sync word, then slices the bits that follow into aligned 16-bit
// payload words. Once per frame it expects the sync word again. A lock/flywheel
// mechanism tolerates up to MAX_MISS-1 consecutive missed sync checks before
// dropping back to hunting.
//
// Ports
//   clk        rising-edge clock, shared with the upstream shift register
//   resetn     synchronous, active-low reset
//   window     shift-register parallel output, bit 0 newest, bit 15 oldest
//   word_out   last captured payload word, held between captures
//   word_valid one-cycle pulse, word_out is new this cycle
//   locked     sync confirmed at the expected frame position
//   sync_err   one-cycle pulse on a missed sync check
module frame_sync_capture #(
    parameter logic [15:0] SYNC_WORD       = 16'hA5C3,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          MAX_MISS        = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] window,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [7:0] LAST_WORD  = 8'(WORDS_PER_FRAME);
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    state_t      state_reg,      state_next;
    logic [3:0]  bit_cnt_reg,    bit_cnt_next;
    logic [7:0]  word_cnt_reg,   word_cnt_next;
    logic [3:0]  miss_cnt_reg,   miss_cnt_next;
    logic [15:0] word_out_reg,   word_out_next;
    logic        word_valid_reg, word_valid_next;
    logic        locked_reg,     locked_next;
    logic        sync_err_reg,   sync_err_next;

    logic        sync_hit;
    logic [3:0]  miss_inc;
    logic [7:0]  word_inc;

    assign sync_hit = (window == SYNC_WORD);
    assign miss_inc = miss_cnt_reg + 4'd1;
    assign word_inc = word_cnt_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= HUNT;
            bit_cnt_reg    <= 4'd0;
            word_cnt_reg   <= 8'd0;
            miss_cnt_reg   <= 4'd0;
            word_out_reg   <= 16'h0000;
            word_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            word_out_reg   <= word_out_next;
            word_valid_reg <= word_valid_next;
            locked_reg     <= locked_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        miss_cnt_next   = miss_cnt_reg;
        word_out_next   = word_out_reg;
        word_valid_next = 1'b0;
        locked_next     = locked_reg;
        sync_err_next   = 1'b0;

        case (state_reg)
            HUNT: begin
                // The edge that samples the match is the frame origin, so the
                // bit counter restarts here and wraps exactly 16 edges later.
                if (sync_hit) begin
                    state_next    = PAYLOAD;
                    bit_cnt_next  = 4'd0;
                    word_cnt_next = 8'd0;
                end
            end

            PAYLOAD: begin
                // Sync-looking data in this state is ignored on purpose:
                // alignment is only ever re-established from HUNT.
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd15) begin
                    word_out_next   = window;
                    word_valid_next = 1'b1;
                    word_cnt_next   = word_inc;
                    if (word_inc == LAST_WORD) begin
                        state_next = CHECK;
                    end
                end
            end

            CHECK: begin
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd15) begin
                    word_cnt_next = 8'd0;
                    if (sync_hit) begin
                        miss_cnt_next = 4'd0;
                        locked_next   = 1'b1;
                        state_next    = PAYLOAD;
                    end else begin
                        sync_err_next = 1'b1;
                        if (miss_inc == MISS_LIMIT) begin
                            locked_next   = 1'b0;
                            miss_cnt_next = 4'd0;
                            state_next    = HUNT;
                        end else begin
                            // Flywheel: keep the assumed frame position.
                            miss_cnt_next = miss_inc;
                            state_next    = PAYLOAD;
                        end
                    end
                end
            end

            default: begin
                state_next = HUNT;
            end
        endcase
    end

    assign word_out   = word_out_reg;
    assign word_valid = word_valid_reg;
    assign locked     = locked_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_frame_sync_capture.sv
// tb_frame_sync_capture
//
// Drives a serial bit stream through a bench-side 16-bit shift register into
// frame_sync_capture and compares every cycle against a reference model that
// tracks frame timing as edge-count arithmetic relative to the last sync
// origin. Scenario tasks add their own checks on captured words and flags.
module tb_frame_sync_capture;

    localparam logic [15:0] SYNC = 16'hA5C3;
    localparam int          W    = 4;
    localparam int          MAXM = 2;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] window = 16'h0000;
    logic [15:0] word_out;
    logic        word_valid;
    logic        locked;
    logic        sync_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_sync_capture #(
        .SYNC_WORD       (SYNC),
        .WORDS_PER_FRAME (W),
        .MAX_MISS        (MAXM)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .window     (window),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    // Reference model: frame slots are positions 16, 32, ... edges after the
    // most recent frame origin (the hunt match or the previous sync check).
    bit          m_hunting  = 1'b1;
    longint      t          = 0;
    longint      anchor     = 0;
    int          m_miss     = 0;
    logic [15:0] exp_word   = 16'h0000;
    logic        exp_valid  = 1'b0;
    logic        exp_locked = 1'b0;
    logic        exp_err    = 1'b0;

    always @(posedge clk) begin
        t         <= t + 1;
        exp_valid <= 1'b0;
        exp_err   <= 1'b0;
        if (!resetn) begin
            m_hunting  <= 1'b1;
            m_miss     <= 0;
            exp_word   <= 16'h0000;
            exp_locked <= 1'b0;
        end else if (m_hunting) begin
            if (window == SYNC) begin
                m_hunting <= 1'b0;
                anchor    <= t;
            end
        end else if ((t - anchor) % 16 == 0) begin
            if ((t - anchor) / 16 <= W) begin
                exp_word  <= window;
                exp_valid <= 1'b1;
            end else begin
                anchor <= t;
                if (window == SYNC) begin
                    m_miss     <= 0;
                    exp_locked <= 1'b1;
                end else begin
                    exp_err <= 1'b1;
                    if (m_miss + 1 == MAXM) begin
                        m_miss     <= 0;
                        exp_locked <= 1'b0;
                        m_hunting  <= 1'b1;
                    end else begin
                        m_miss <= m_miss + 1;
                    end
                end
            end
        end
    end

    // Shift one bit into the window; returns at the following falling edge.
    task automatic drive_bit(input logic b);
        window = {window[14:0], b};
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset while flushing the window with zeros (zeros never match the sync).
    task automatic restart();
        resetn = 1'b0;
        for (int i = 0; i < 16; i++) drive_bit(1'b0);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_bit(1'($urandom_range(0, 1)));
            checks++;
            if ({word_out, word_valid, locked, sync_err} !== 19'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got out=%h v=%b l=%b e=%b want all zero",
                         i, word_out, word_valid, locked, sync_err);
            end
        end
        restart();
        $display("reset: outputs out=%h v=%b l=%b e=%b", word_out, word_valid, locked, sync_err);
    endtask

    task automatic test_clean_frame();
        logic [15:0] s[6];
        logic [15:0] got[$];
        s = '{SYNC, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, SYNC};
        for (int w = 0; w < 6; w++) begin
            for (int i = 15; i >= 0; i--) begin
                drive_bit(s[w][i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL clean_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) got.push_back(word_out);
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL clean_count got %0d words want 4", got.size());
        end
        for (int j = 0; j < got.size() && j < 4; j++) begin
            checks++;
            if (got[j] !== s[j+1]) begin
                errors++;
                $display("FAIL clean_word%0d got %h want %h", j, got[j], s[j+1]);
            end
        end
        checks++;
        if (locked !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_lock got locked=%b valid=%b want locked=1 valid=0", locked, word_valid);
        end
        $display("clean_frame: %0d words, locked=%b", got.size(), locked);
    endtask

    task automatic test_false_sync();
        logic [15:0] s[5];
        logic [15:0] got[$];
        s = '{SYNC, 16'h1111, 16'h2222, 16'h3333, SYNC};
        for (int w = 0; w < 5; w++) begin
            for (int i = 15; i >= 0; i--) begin
                drive_bit(s[w][i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL falsesync_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) got.push_back(word_out);
            end
        end
        checks++;
        if (got.size() != 4 || locked !== 1'b1) begin
            errors++;
            $display("FAIL falsesync_count got %0d words locked=%b want 4 words locked=1", got.size(), locked);
        end
        for (int j = 0; j < got.size() && j < 4; j++) begin
            checks++;
            if (got[j] !== s[j]) begin
                errors++;
                $display("FAIL falsesync_word%0d got %h want %h", j, got[j], s[j]);
            end
        end
        $display("false_sync: %0d words, locked=%b", got.size(), locked);
    endtask

    task automatic test_flywheel();
        logic [15:0] s[24];
        logic [15:0] want[$];
        logic [15:0] got[$];
        int          err_pulses = 0;
        for (int w = 0; w < 24; w++) begin
            if (w >= 20) s[w] = 16'h0000;
            else if (w == 4 || w == 14 || w == 19) s[w] = SYNC ^ 16'h0001;
            else if (w == 9) s[w] = SYNC;
            else begin
                s[w] = 16'($urandom);
                want.push_back(s[w]);
            end
        end
        for (int w = 0; w < 24; w++) begin
            for (int i = 15; i >= 0; i--) begin
                drive_bit(s[w][i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL flywheel_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) got.push_back(word_out);
                if (sync_err) err_pulses++;
            end
            if (w == 4) begin
                checks++;
                if (locked !== 1'b1 || sync_err !== 1'b1) begin
                    errors++;
                    $display("FAIL flywheel_single got locked=%b err=%b want 1/1", locked, sync_err);
                end
            end
            if (w == 19) begin
                checks++;
                if (locked !== 1'b0 || sync_err !== 1'b1) begin
                    errors++;
                    $display("FAIL flywheel_drop got locked=%b err=%b want 0/1", locked, sync_err);
                end
            end
        end
        checks++;
        if (err_pulses != 3 || got.size() != want.size()) begin
            errors++;
            $display("FAIL flywheel_counts got err=%0d words=%0d want err=3 words=%0d",
                     err_pulses, got.size(), want.size());
        end
        for (int j = 0; j < got.size() && j < want.size(); j++) begin
            checks++;
            if (got[j] !== want[j]) begin
                errors++;
                $display("FAIL flywheel_word%0d got %h want %h", j, got[j], want[j]);
            end
        end
        $display("flywheel: %0d words, %0d sync errors, locked=%b", got.size(), err_pulses, locked);
    endtask

    task automatic test_reset_mid_payload();
        logic [15:0] s[6];
        logic [15:0] got[$];
        int          n = 0;
        restart();
        // SYNC at edge k, word 1 at k+16, reset at k+24 (8th bit of word 2).
        s = '{SYNC, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h0000};
        for (int w = 0; w < 6; w++) begin
            for (int i = 15; i >= 0; i--) begin
                n++;
                resetn = (n == 40) ? 1'b0 : 1'b1;
                drive_bit(s[w][i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL midreset_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) got.push_back(word_out);
            end
        end
        resetn = 1'b1;
        checks++;
        if (got.size() != 1 || (got.size() == 1 && got[0] !== 16'h1234)) begin
            errors++;
            $display("FAIL midreset_words got %0d words want only 1234", got.size());
        end
        got.delete();
        s = '{SYNC, 16'hCAFE, 16'hBEEF, 16'h0F0F, 16'h7777, SYNC};
        for (int w = 0; w < 6; w++) begin
            for (int i = 15; i >= 0; i--) begin
                drive_bit(s[w][i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL relock_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) got.push_back(word_out);
            end
        end
        checks++;
        if (got.size() != 4 || locked !== 1'b1) begin
            errors++;
            $display("FAIL relock got %0d words locked=%b want 4 words locked=1", got.size(), locked);
        end
        $display("reset_mid_payload: relock words=%0d locked=%b", got.size(), locked);
    endtask

    task automatic test_near_miss();
        int valids = 0;
        restart();
        for (int w = 0; w < 8; w++) begin
            logic [15:0] v;
            v = (w % 2 == 0) ? 16'hA5C2 : 16'h0000;
            if (w == 5) v = 16'hA5C2;
            for (int i = 15; i >= 0; i--) begin
                drive_bit(v[i]);
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL nearmiss_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
                if (word_valid) valids++;
            end
        end
        checks++;
        if (valids != 0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL nearmiss got valids=%0d locked=%b want 0/0", valids, locked);
        end
        $display("near_miss: valids=%0d locked=%b", valids, locked);
    endtask

    task automatic test_random();
        restart();
        for (int f = 0; f < 12; f++) begin
            logic [15:0] s[W+1];
            int          junk;
            s[0] = SYNC;
            if ($urandom_range(0, 3) == 0) s[0] = SYNC ^ (16'h1 << $urandom_range(0, 15));
            for (int j = 1; j <= W; j++) s[j] = 16'($urandom);
            junk = (f % 4 == 0) ? $urandom_range(0, 20) : 0;
            for (int b = 0; b < junk; b++) begin
                drive_bit(1'($urandom_range(0, 1)));
                checks++;
                if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                    errors++;
                    $display("FAIL random_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                end
            end
            for (int w = 0; w <= W; w++) begin
                for (int i = 15; i >= 0; i--) begin
                    drive_bit(s[w][i]);
                    checks++;
                    if ({word_out, word_valid, locked, sync_err} !== {exp_word, exp_valid, exp_locked, exp_err}) begin
                        errors++;
                        $display("FAIL random_model t=%0d got %h/%b/%b/%b want %h/%b/%b/%b", t,
                                 word_out, word_valid, locked, sync_err, exp_word, exp_valid, exp_locked, exp_err);
                    end
                end
            end
            $display("random frame %0d: sync=%h locked=%b", f, s[0], locked);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_frame();
        test_false_sync();
        test_flywheel();
        test_reset_mid_payload();
        test_near_miss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
